// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO definitions for the riscv_core peripheral slice: UART window, register
// word offsets, STATUS bit positions and the UART transmit FSM encoding.
package riscv_mmio_pkg;

  localparam logic [31:0] MMIO_UART_BASE = 32'hFFFF0018;
  localparam logic [31:0] MMIO_WIN_BYTES = 32'd16;

  // Word offsets within a 16-byte window (addr[3:2] after base subtraction)
  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;
  localparam logic [1:0] REG_IRQ_EN   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A programmed divider of zero behaves like one cycle per bit
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous circular buffer for the UART transmitter. A push while full
// is accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic                              pop,
  input  logic [7:0]                        din,
  output logic [7:0]                        dout,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH):0]       count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the core load/store path.
// Define UART_TX_IRQ_EN to add the IRQ_EN register at +0xC and the tx_irq output.
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MMIO_UART_BASE,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        sel,
  output logic [31:0] rdata,
`ifdef UART_TX_IRQ_EN
  output logic        tx_irq,
`endif
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus protocol: a store takes effect on the posedge where mem_write & sel is high;
  // loads are side-effect free and rdata/sel are purely combinational from addr.
  logic [31:0]   off;
  logic [1:0]    word;
  logic          wr;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   reload;
  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [15:0]   cnt;
  logic          bit_end;
  logic          busy;
  logic [31:0]   status;
  logic          unused_bits;

  assign off         = addr - BASE_ADDR;
  assign sel         = (off < MMIO_WIN_BYTES);
  assign word        = off[3:2];
  assign wr          = mem_write & sel;
  assign push        = wr & (word == REG_TXDATA);
  assign busy        = (state != S_IDLE);
  assign bit_end     = (cnt == 16'd0);
  assign reload      = eff_div(baud_div) - 16'd1;
  assign pop         = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign unused_bits = ^wdata[31:16];

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (wr && word == REG_STATUS && wdata[ST_OVF]) overflow <= 1'b0;
      if (wr && word == REG_BAUD_DIV) baud_div <= wdata[15:0];
    end
  end

  // The divider is sampled only at bit-boundary reloads, so a mid-frame BAUD_DIV
  // write leaves the bit in flight untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
      cnt     <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            shift <= fifo_dout;
            tx    <= 1'b0;
            cnt   <= reload;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= 3'd0;
            cnt     <= reload;
            state   <= S_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= reload;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              shift <= fifo_dout;
              tx    <= 1'b0;
              cnt   <= reload;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      if (wr && word == REG_IRQ_EN) irq_en <= wdata[0];
      tx_irq <= irq_en & fifo_empty & ~busy;
    end
  end
`endif

  always_comb begin
    status                     = '0;
    status[ST_BUSY]            = busy;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_OVF]             = overflow;
    status[ST_CNT_LSB +: 4]    = 4'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (sel && mem_read) begin
      case (word)
        REG_STATUS:   rdata = status;
        REG_BAUD_DIV: rdata = {16'h0000, baud_div};
`ifdef UART_TX_IRQ_EN
        REG_IRQ_EN:   rdata = {31'd0, irq_en};
`else
        REG_IRQ_EN:   rdata = '0;
`endif
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus hand-written
// frame, back-to-back/overflow, zero-divider, IRQ and mid-frame reset sequences.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        tx_irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  localparam logic [31:0] A_TXDATA = 32'hFFFF0018;
  localparam logic [31:0] A_STATUS = 32'hFFFF001C;
  localparam logic [31:0] A_BAUD   = 32'hFFFF0020;
  localparam logic [31:0] A_RSVD   = 32'hFFFF0024;
  localparam logic [31:0] A_GPIO   = 32'hFFFF0010;

  mmio_uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .sel       (sel),
    .rdata     (rdata),
`ifdef UART_TX_IRQ_EN
    .tx_irq    (tx_irq),
`endif
    .tx        (tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks: called just after a posedge; a write occupies exactly one edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = rdata;
    mem_read = 1'b0;
    addr     = 32'h0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pops the next expected byte and checks its whole 8N1 frame on tx,
  // starting in the first cycle of the start bit
  task automatic check_frame(input int div);
    logic [7:0] b;
    logic [9:0] frame;
    if (exp_q.size() == 0) begin
      check("frame_queue_empty", 32'd0, 32'd1);
      return;
    end
    b     = exp_q.pop_front();
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < div; c++) begin
        check($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c), {31'd0, tx}, {31'd0, frame[k]});
        tick();
      end
    end
  endtask

  initial begin
    int lows;
    rst       = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_write = 1'b0;
    mem_read  = 1'b0;

    vecs[0]  = '{A_STATUS,     32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0004};
    vecs[1]  = '{A_BAUD,       32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0364};
    vecs[2]  = '{A_TXDATA,     32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[3]  = '{A_RSVD,       32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[4]  = '{A_GPIO,       32'h0,    1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[5]  = '{32'hFFFF0028, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[6]  = '{32'hFFFF0017, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[7]  = '{32'hFFFF0027, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0000};
    vecs[8]  = '{32'hFFFF0021, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0364};
    vecs[9]  = '{A_STATUS,     32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[10] = '{A_GPIO,       32'hFFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("tx_in_reset", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    tick();
    check("tx_after_reset", {31'd0, tx}, 32'd1);

    // register-access vector table
    for (int i = 0; i < 11; i++) begin
      addr      = vecs[i].addr;
      wdata     = vecs[i].wdata;
      mem_write = vecs[i].we;
      mem_read  = vecs[i].re;
      #1;
      check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
    end
    check_reg("baud_after_gpio_write", A_BAUD, 32'h0000_0364);
    check_reg("status_after_gpio_write", A_STATUS, 32'h0000_0004);
    check("tx_after_gpio_write", {31'd0, tx}, 32'd1);

    // single frame, 4-cycle bits
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TXDATA, 32'h0000_00A5);
    exp_q.push_back(8'hA5);
    check("a5_tx_at_write_edge", {31'd0, tx}, 32'd1);
    check_reg("a5_status_queued", A_STATUS, 32'h0000_0010);
    tick();
    check_reg("a5_status_busy", A_STATUS, 32'h0000_0005);
    check_frame(4);
    check_reg("a5_status_done", A_STATUS, 32'h0000_0004);

    // six consecutive pushes with 2-cycle bits: one pops at once, four queue, one overflows
    bus_write(A_BAUD, 32'd2);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    fork
      begin
        for (int i = 1; i <= 6; i++) bus_write(A_TXDATA, 32'(i));
        check_reg("ovf_status_full", A_STATUS, 32'h0000_004B);
      end
      begin
        tick();
        tick();
        for (int f = 0; f < 5; f++) check_frame(2);
      end
    join
    check_reg("ovf_status_idle", A_STATUS, 32'h0000_000C);
    bus_write(A_STATUS, 32'h0000_0008);
    check_reg("ovf_cleared", A_STATUS, 32'h0000_0004);
    check("tx_after_burst", {31'd0, tx}, 32'd1);

    // zero divider behaves as one cycle per bit
    bus_write(A_BAUD, 32'd0);
    check_reg("baud_zero_readback", A_BAUD, 32'h0000_0000);
    bus_write(A_TXDATA, 32'h0000_003C);
    exp_q.push_back(8'h3C);
    tick();
    check_frame(1);
    check_reg("div0_status_done", A_STATUS, 32'h0000_0004);

`ifdef UART_TX_IRQ_EN
    check("irq_idle_disabled", {31'd0, tx_irq}, 32'd0);
    bus_write(A_RSVD, 32'd1);
    check("irq_write_edge", {31'd0, tx_irq}, 32'd0);
    tick();
    check("irq_asserted", {31'd0, tx_irq}, 32'd1);
    check_reg("irq_en_readback", A_RSVD, 32'h0000_0001);
    bus_write(A_TXDATA, 32'h0000_0055);
    exp_q.push_back(8'h55);
    tick();
    check("irq_dropped", {31'd0, tx_irq}, 32'd0);
    check_frame(1);
    check("irq_stop_edge", {31'd0, tx_irq}, 32'd0);
    tick();
    check("irq_reasserted", {31'd0, tx_irq}, 32'd1);
`endif

    // asynchronous reset in the middle of a data bit with two bytes still queued
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TXDATA, 32'h0);
    bus_write(A_TXDATA, 32'h0);
    bus_write(A_TXDATA, 32'h0);
    repeat (10) tick();
    check("rst_pre_tx_low", {31'd0, tx}, 32'd0);
    check_reg("rst_pre_status", A_STATUS, 32'h0000_0021);
    rst = 1'b0;
    #1;
    check("rst_async_tx_high", {31'd0, tx}, 32'd1);
    check_reg("rst_status_in_reset", A_STATUS, 32'h0000_0004);
    tick();
    rst = 1'b1;
    tick();
    check_reg("rst_status_after", A_STATUS, 32'h0000_0004);
    check_reg("rst_baud_after", A_BAUD, 32'h0000_0364);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("rst_no_further_frames", 32'(lows), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
